byte_write_sp_rf_ram: RTL and testbench
=======================================

// Module: byte_write_sp_rf_ram
//
// PURPOSE
// - Single-port, read-first synchronous RAM with a per-byte (column) write enable.
// - Serves as the data array of one L1 data-cache way: one instance per way, one line per set.
// - Kept as a standalone module so synthesis infers a byte-enable BlockRAM.
//   Vivado does not infer byte enables on a 3D array inside the cache.
//
// PARAMETERS
// - COLS       default 16  number of byte columns per word; 16 gives a 128-bit cache line
// - COL_WIDTH  default 8   bits per column
// - ADDR_BITS  default 3   address width; DEPTH = 2**ADDR_BITS words
//
// PORTS
// - clk     in   1                 clock; all activity on the rising edge
// - rst     in   1                 reset, synchronous, active-high
// - en      in   1                 port enable; gates both read and write
// - we      in   COLS              byte write enable; bit c controls column c
// - addr    in   ADDR_BITS         word address
// - data_i  in   COLS*COL_WIDTH    write data; column c = data_i[c*COL_WIDTH +: COL_WIDTH]
// - data_o  out  COLS*COL_WIDTH    registered read data
//
// BEHAVIOUR
// - Storage: mem[DEPTH] of COLS*COL_WIDTH bits. All words initialise to 0 at configuration
//   (initial block). Storage is never cleared by rst.
// - Reset, rst=1 at a rising edge:
//   - data_o <= 0.
//   - No write occurs, regardless of en/we.
//   - rst has priority over en.
// - Access, rst=0 and en=1 at a rising edge:
//   - Read-first: data_o <= mem[addr] as it was before this edge's write.
//   - For each c with we[c]=1: mem[addr][c] <= data_i column c.
//   - Columns with we[c]=0 keep their value.
//   - we=0 gives a pure read; we='1 gives a full-word write.
// - Idle, rst=0 and en=0: data_o holds its last value; memory is unchanged; we/addr/data_i are ignored.
// - Latency: read data appears on data_o exactly 1 cycle after the enabled edge.
//   There is no combinational path from any input to data_o.
// - Write at edge N, then read of the same addr at edge N+1: data_o returns the new data.
//   There is no write-to-read hazard beyond the read-first rule.
// - Any we pattern is legal, including non-contiguous bytes. Every addr value is in range,
//   so there is no out-of-range case.
// - No handshake and no backpressure; one access per cycle.
// - The cache instantiates this block as an array, one per way. Every port is per-instance.
//
// STRUCTURE
// - Single flat module with no sub-modules.
//   - One always_ff: rst branch, then en branch.
//   - Inside the en branch, a for-loop over COLS applies the byte writes.
//   - The read is a non-blocking assignment in the same always_ff (read-first inference template).
// - No package types are required. The cache binds data_i/data_o to Mem::line_t and we to
//   Mem::linemask_t; those typedefs stay in the shared Mem package.
// - Elaboration checks: COLS>=1, COL_WIDTH>=1, ADDR_BITS>=1.
//
// TESTING
// Directed scenarios, with COLS=16, COL_WIDTH=8, ADDR_BITS=3:
// 1. Init/reset
//    - Stimulus: rst=1 for one edge, then read every addr 0..7 with we=0.
//    - Required: data_o=0 after reset; every read returns 0.
// 2. Full write, then read
//    - Stimulus: en=1, we=16'hFFFF, addr=5, data_i=128'h0F0E..0100.
//    - Required: data_o shows the old value (0) on the next cycle.
//    - Then: reading addr 5 returns 128'h0F0E..0100.
// 3. Byte mask
//    - Stimulus: on addr 5, write we=16'h000F, data_i=all 0xAA.
//    - Required: readback is 0x0F0E0D0C_0B0A0908_07060504_AAAAAAAA; bytes 4..15 are unchanged.
// 4. Read-first
//    - Stimulus: write addr 2 = X, then write addr 2 = Y with we='1.
//    - Required: data_o = X after the second edge; the next read of addr 2 = Y.
// 5. Enable gating
//    - Stimulus: en=0 with we='1, addr=5, data_i=0.
//    - Required: data_o holds its last value; a later read of addr 5 is unchanged.
// 6. Reset mid-operation
//    - Stimulus: rst=1 together with en=1, we='1, addr=1.
//    - Required: data_o=0; addr 1 is not written; the prior contents of addr 5 are still intact.

Source files
------------

// File: rtl/byte_write_sp_rf_ram_pkg.sv
// Shared constants for the byte-write single-port RAM. These are the default
// geometry values, which give one 128-bit cache line per word and 8 sets.
package byte_write_sp_rf_ram_pkg;

    localparam int DEFAULT_COLS      = 16;
    localparam int DEFAULT_COL_WIDTH = 8;
    localparam int DEFAULT_ADDR_BITS = 3;

    // Total word width for a given column geometry.
    function automatic int line_bits(input int cols, input int col_width);
        return cols * col_width;
    endfunction

endpackage : byte_write_sp_rf_ram_pkg

// File: rtl/byte_write_sp_rf_ram.sv
// Single-port, read-first synchronous RAM with a per-byte (column) write enable.
// This is the data array of one L1 data-cache way. It stays a standalone flat
// module so that synthesis can map it onto a byte-enable block RAM.
//
// Access protocol: there is no handshake and no backpressure. Each rising edge
// with en=1 (and rst=0) is one access. The read returns the word as it was
// before that edge's write, and data_o is valid one cycle later. With en=0,
// data_o holds its value and the memory ignores we/addr/data_i.
module byte_write_sp_rf_ram
    import byte_write_sp_rf_ram_pkg::*;
#(
    parameter int COLS      = DEFAULT_COLS,
    parameter int COL_WIDTH = DEFAULT_COL_WIDTH,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [COLS-1:0]           we,
    input  logic [ADDR_BITS-1:0]      addr,
    input  logic [COLS*COL_WIDTH-1:0] data_i,
    output logic [COLS*COL_WIDTH-1:0] data_o
);

    localparam int WIDTH = line_bits(COLS, COL_WIDTH);
    localparam int DEPTH = 2 ** ADDR_BITS;

    // Reject geometries that cannot describe a real memory.
    if (COLS < 1) begin : g_bad_cols
        $error("byte_write_sp_rf_ram: COLS must be at least 1");
    end
    if (COL_WIDTH < 1) begin : g_bad_col_width
        $error("byte_write_sp_rf_ram: COL_WIDTH must be at least 1");
    end
    if (ADDR_BITS < 1) begin : g_bad_addr_bits
        $error("byte_write_sp_rf_ram: ADDR_BITS must be at least 1");
    end

    // Contents are zero at configuration. rst never clears them, because a
    // cache reset invalidates tags rather than wiping the data arrays.
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Read-first access: the read samples the old word, and the enabled
    // columns are then overwritten on the same edge. rst blocks both.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
        end else if (en) begin
            data_o <= mem[addr];
            for (int c = 0; c < COLS; c++) begin
                if (we[c]) begin
                    mem[addr][c*COL_WIDTH +: COL_WIDTH] <= data_i[c*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

endmodule : byte_write_sp_rf_ram

// File: tb/tb_byte_write_sp_rf_ram.sv
// Self-checking bench for byte_write_sp_rf_ram (16 x 8-bit columns, 8 words).
module tb_byte_write_sp_rf_ram;

    localparam int COLS      = 16;
    localparam int COL_WIDTH = 8;
    localparam int ADDR_BITS = 3;
    localparam int W         = COLS * COL_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_BITS;

    // ---------------- clock / reset ----------------
    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 en  = 1'b0;
    logic [COLS-1:0]      we  = '0;
    logic [ADDR_BITS-1:0] addr = '0;
    logic [W-1:0]         data_i = '0;
    logic [W-1:0]         data_o;

    always #5 clk = ~clk;

    byte_write_sp_rf_ram #(
        .COLS      (COLS),
        .COL_WIDTH (COL_WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .we     (we),
        .addr   (addr),
        .data_i (data_i),
        .data_o (data_o)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0] model_mem [DEPTH];
    logic [W-1:0] model_out;
    logic [W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    // Expand a byte-enable vector into a bit mask.
    function automatic logic [W-1:0] byte_mask(input logic [COLS-1:0] m);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++)
            if (m[c]) r = r | ({{(W-COL_WIDTH){1'b0}}, {COL_WIDTH{1'b1}}} << (c * COL_WIDTH));
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] expected);
        checks++;
        assert (data_o === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, data_o, expected);
        end
    endtask

    // ---------------- driver ----------------
    // One clock: drive on the falling edge, let the model take the rising
    // edge, then check 1 time unit later against the queued expectation.
    task automatic cycle(input string tag, input logic r, input logic e,
                         input logic [COLS-1:0] w, input logic [ADDR_BITS-1:0] a,
                         input logic [W-1:0] d);
        logic [W-1:0] m;
        @(negedge clk);
        rst = r; en = e; we = w; addr = a; data_i = d;
        @(posedge clk);
        if (r) begin
            model_out = '0;
        end else if (e) begin
            model_out = model_mem[a];
            m = byte_mask(w);
            model_mem[a] = (model_mem[a] & ~m) | (d & m);
        end
        exp_q.push_back(model_out);
        #1;
        check(tag, exp_q.pop_front());
    endtask

    logic [W-1:0] line_a, line_b, line_x, line_y;

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_out = '0;
        line_a = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        line_b = 128'h0F0E0D0C_0B0A0908_07060504_AAAAAAAA;
        line_x = {$urandom, $urandom, $urandom, $urandom};
        line_y = {$urandom, $urandom, $urandom, $urandom};

        // 1. Reset, then every word reads back zero.
        cycle("reset", 1'b1, 1'b0, '0, '0, '0);
        check("reset_zero", '0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle("init_read", 1'b0, 1'b1, '0, ADDR_BITS'(i), {$urandom, $urandom, $urandom, $urandom});
            check("init_zero", '0);
        end

        // 2. Full write, then read back.
        cycle("full_write_old", 1'b0, 1'b1, 16'hFFFF, 3'd5, line_a);
        check("full_write_old_zero", '0);
        cycle("full_read", 1'b0, 1'b1, '0, 3'd5, '0);
        check("full_read_const", line_a);

        // 3. Byte-masked write of the low four bytes.
        cycle("mask_write", 1'b0, 1'b1, 16'h000F, 3'd5, {16{8'hAA}});
        cycle("mask_read", 1'b0, 1'b1, '0, 3'd5, '0);
        check("mask_read_const", line_b);

        // 4. Read-first: the second write returns the first write's data.
        cycle("rf_write_x", 1'b0, 1'b1, 16'hFFFF, 3'd2, line_x);
        cycle("rf_write_y", 1'b0, 1'b1, 16'hFFFF, 3'd2, line_y);
        check("rf_old_x", line_x);
        cycle("rf_read_y", 1'b0, 1'b1, '0, 3'd2, '0);
        check("rf_new_y", line_y);

        // 5. en=0 blocks the write and holds data_o.
        cycle("idle_hold", 1'b0, 1'b0, 16'hFFFF, 3'd5, '0);
        check("idle_hold_y", line_y);
        cycle("idle_read", 1'b0, 1'b1, '0, 3'd5, '0);
        check("idle_mem_kept", line_b);

        // 6. rst overrides an enabled full write.
        cycle("rst_mid", 1'b1, 1'b1, 16'hFFFF, 3'd1, line_x);
        check("rst_mid_zero", '0);
        cycle("rst_addr1", 1'b0, 1'b1, '0, 3'd1, '0);
        check("rst_addr1_zero", '0);
        cycle("rst_addr5", 1'b0, 1'b1, '0, 3'd5, '0);
        check("rst_addr5_kept", line_b);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle("random",
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) != 0),
                  COLS'($urandom),
                  ADDR_BITS'($urandom_range(0, DEPTH - 1)),
                  {$urandom, $urandom, $urandom, $urandom});
        end

        // Final sweep of every word against the model.
        for (int i = 0; i < DEPTH; i++)
            cycle("final_read", 1'b0, 1'b1, '0, ADDR_BITS'(i), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_byte_write_sp_rf_ram
